// File: rtl/phase_stats_pkg.sv
// rtl/phase_stats_pkg.sv - shared widths, state encoding and glitch check for phase_stats
package phase_stats_pkg;

   localparam int PHASE_W = 9;
   localparam int HALF_W  = 8;
   localparam int CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Edge counts that disagree by more than one tick indicate a glitched measurement.
   function automatic logic is_glitch(input logic [HALF_W-1:0] lo, input logic [HALF_W-1:0] hi);
      logic [HALF_W-1:0] diff;
      diff = (lo > hi) ? (lo - hi) : (hi - lo);
      return diff > HALF_W'(1);
   endfunction

endpackage

// File: rtl/phase_stats_if.sv
// rtl/phase_stats_if.sv - measurement input and window statistics bundle for phase_stats
interface phase_stats_if;
   import phase_stats_pkg::*;

   logic [2*HALF_W-1:0] phase_diff;
   logic                phase_valid;
   logic [PHASE_W-1:0]  mean;
   logic [PHASE_W-1:0]  min_val;
   logic [PHASE_W-1:0]  max_val;
   logic                stats_valid;

   modport master (
      output phase_diff,
      output phase_valid,
      input  mean,
      input  min_val,
      input  max_val,
      input  stats_valid
   );

   modport slave (
      input  phase_diff,
      input  phase_valid,
      output mean,
      output min_val,
      output max_val,
      output stats_valid
   );

endinterface

// File: rtl/phase_lock_tracker.sv
// rtl/phase_lock_tracker.sv - counts consecutive tight windows and raises locked
module phase_lock_tracker
   import phase_stats_pkg::*;
#(
   parameter int LOCK_TOL     = 2,
   parameter int LOCK_WINDOWS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_i,
   input  logic               window_done_i,
   input  logic [PHASE_W-1:0] spread_i,
   output logic               locked_o
);

   localparam int LW_W = $clog2(LOCK_WINDOWS + 1);
   localparam logic [LW_W-1:0] LW_MAX = LW_W'(LOCK_WINDOWS);

   logic [LW_W-1:0] cnt_q, cnt_d;
   logic            locked_q, locked_d;
   logic            good;

   assign good = spread_i <= PHASE_W'(LOCK_TOL);

   always_comb begin
      cnt_d    = cnt_q;
      locked_d = locked_q;
      if (clear_i) begin
         cnt_d    = '0;
         locked_d = 1'b0;
      end else if (window_done_i) begin
         if (!good) begin
            cnt_d = '0;
         end else if (cnt_q != LW_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
         locked_d = (cnt_d == LW_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
      end
   end

   assign locked_o = locked_q;

endmodule

// File: rtl/phase_stats.sv
// rtl/phase_stats.sv - windowed mean/min/max and lock detection on echo phase samples
// Optional idle timeout compiled in with PHASE_STATS_TIMEOUT_EN.
module phase_stats
   import phase_stats_pkg::*;
#(
   parameter int LOG2_N       = 4,
   parameter int LOCK_TOL     = 2,
   parameter int LOCK_WINDOWS = 4
`ifdef PHASE_STATS_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_i,
   phase_stats_if.slave     ps_if,
   output logic             locked_o,
   output logic [CNT_W-1:0] window_cnt_o,
   output logic [CNT_W-1:0] reject_cnt_o,
   output logic             timeout_o
);

   localparam int SUM_W = PHASE_W + LOG2_N;
   localparam logic [LOG2_N-1:0] N_LAST = '1;

   state_e               state_q, state_d;
   logic [SUM_W-1:0]     sum_q, sum_d;
   logic [LOG2_N-1:0]    n_q, n_d;
   logic [PHASE_W-1:0]   run_min_q, run_min_d;
   logic [PHASE_W-1:0]   run_max_q, run_max_d;
   logic [PHASE_W-1:0]   mean_q, mean_d;
   logic [PHASE_W-1:0]   min_q, min_d;
   logic [PHASE_W-1:0]   max_q, max_d;
   logic                 stats_valid_q, stats_valid_d;
   logic [CNT_W-1:0]     window_cnt_q, window_cnt_d;
   logic [CNT_W-1:0]     reject_cnt_q, reject_cnt_d;

   logic [HALF_W-1:0]    lo, hi;
   logic [PHASE_W-1:0]   combined;
   logic                 glitch, in_accum, accept, reject;
   logic                 clear_acc, lock_clear, window_done;
   logic                 timeout_fire;

   assign lo       = ps_if.phase_diff[HALF_W-1:0];
   assign hi       = ps_if.phase_diff[2*HALF_W-1:HALF_W];
   assign combined = PHASE_W'(lo) + PHASE_W'(hi);
   assign glitch   = is_glitch(lo, hi);
   assign in_accum = (state_q == ACCUM) && enable_i;
   assign accept   = in_accum && ps_if.phase_valid && !glitch;
   assign reject   = in_accum && ps_if.phase_valid && glitch;

   always_comb begin
      state_d       = state_q;
      sum_d         = sum_q;
      n_d           = n_q;
      run_min_d     = run_min_q;
      run_max_d     = run_max_q;
      mean_d        = mean_q;
      min_d         = min_q;
      max_d         = max_q;
      stats_valid_d = 1'b0;
      window_cnt_d  = window_cnt_q;
      reject_cnt_d  = reject_cnt_q;
      clear_acc     = 1'b0;
      lock_clear    = 1'b0;
      window_done   = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable_i) begin
               state_d   = ACCUM;
               clear_acc = 1'b1;
            end
         end
         ACCUM: begin
            if (!enable_i) begin
               state_d    = IDLE;
               clear_acc  = 1'b1;
               lock_clear = 1'b1;
            end else if (accept) begin
               sum_d     = sum_q + SUM_W'(combined);
               n_d       = n_q + 1'b1;
               run_min_d = (combined < run_min_q) ? combined : run_min_q;
               run_max_d = (combined > run_max_q) ? combined : run_max_q;
               if (n_q == N_LAST) state_d = DONE;
            end
         end
         DONE: begin
            // sum already includes the N-th sample taken on the edge into DONE
            mean_d        = sum_q[LOG2_N +: PHASE_W];
            min_d         = run_min_q;
            max_d         = run_max_q;
            stats_valid_d = 1'b1;
            window_cnt_d  = window_cnt_q + 1'b1;
            window_done   = 1'b1;
            clear_acc     = 1'b1;
            state_d       = enable_i ? ACCUM : IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (reject && (reject_cnt_q != '1)) reject_cnt_d = reject_cnt_q + 1'b1;

      if (timeout_fire) begin
         clear_acc  = 1'b1;
         lock_clear = 1'b1;
      end

      if (clear_acc) begin
         sum_d     = '0;
         n_d       = '0;
         run_min_d = '1;
         run_max_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         sum_q         <= '0;
         n_q           <= '0;
         run_min_q     <= '1;
         run_max_q     <= '0;
         mean_q        <= '0;
         min_q         <= '0;
         max_q         <= '0;
         stats_valid_q <= 1'b0;
         window_cnt_q  <= '0;
         reject_cnt_q  <= '0;
      end else begin
         state_q       <= state_d;
         sum_q         <= sum_d;
         n_q           <= n_d;
         run_min_q     <= run_min_d;
         run_max_q     <= run_max_d;
         mean_q        <= mean_d;
         min_q         <= min_d;
         max_q         <= max_d;
         stats_valid_q <= stats_valid_d;
         window_cnt_q  <= window_cnt_d;
         reject_cnt_q  <= reject_cnt_d;
      end
   end

`ifdef PHASE_STATS_TIMEOUT_EN
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic             timeout_q, timeout_d;

   // Counts ACCUM cycles with no measurement at all; fires on the TIMEOUT_CYCLES-th.
   always_comb begin
      idle_cnt_d   = '0;
      timeout_fire = 1'b0;
      timeout_d    = timeout_q;
      if (in_accum && !ps_if.phase_valid) begin
         if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_fire = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
      if (timeout_fire)  timeout_d = 1'b1;
      else if (accept)   timeout_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_fire = 1'b0;
   assign timeout_o    = 1'b0;
`endif

   phase_lock_tracker #(
      .LOCK_TOL     (LOCK_TOL),
      .LOCK_WINDOWS (LOCK_WINDOWS)
   ) u_lock (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (lock_clear),
      .window_done_i (window_done),
      .spread_i      (run_max_q - run_min_q),
      .locked_o      (locked_o)
   );

   assign ps_if.mean        = mean_q;
   assign ps_if.min_val     = min_q;
   assign ps_if.max_val     = max_q;
   assign ps_if.stats_valid = stats_valid_q;
   assign window_cnt_o      = window_cnt_q;
   assign reject_cnt_o      = reject_cnt_q;

endmodule

// File: tb/tb_phase_stats.sv
// tb/tb_phase_stats.sv - directed checks of phase_stats windows, rejects, lock and timeout
module tb_phase_stats;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        locked;
   logic [15:0] window_cnt;
   logic [15:0] reject_cnt;
   logic        timeout;

   int n_checks = 0;
   int n_errors = 0;
   int exp_wc   = 0;

   phase_stats_if u_if ();

   always #5 clk = ~clk;

`ifdef PHASE_STATS_TIMEOUT_EN
   phase_stats #(.LOG2_N(4), .LOCK_TOL(2), .LOCK_WINDOWS(4), .TIMEOUT_CYCLES(100)) u_dut (
`else
   phase_stats #(.LOG2_N(4), .LOCK_TOL(2), .LOCK_WINDOWS(4)) u_dut (
`endif
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable),
      .ps_if        (u_if),
      .locked_o     (locked),
      .window_cnt_o (window_cnt),
      .reject_cnt_o (reject_cnt),
      .timeout_o    (timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_n(input int n, input logic [7:0] lo, input logic [7:0] hi);
      for (int i = 0; i < n; i++) begin
         u_if.phase_valid = 1'b1;
         u_if.phase_diff  = {hi, lo};
         tick();
      end
      u_if.phase_valid = 1'b0;
   endtask

   // Called in the cycle after the N-th sample: stats must appear exactly one cycle later.
   task automatic expect_stats(input string tag, input logic [8:0] m, input logic [8:0] mn,
                               input logic [8:0] mx, input logic lk);
      check({tag, "_early"}, u_if.stats_valid, 1'b0);
      tick();
      exp_wc++;
      check({tag, "_sv"}, u_if.stats_valid, 1'b1);
      check({tag, "_mean"}, u_if.mean, m);
      check({tag, "_min"}, u_if.min_val, mn);
      check({tag, "_max"}, u_if.max_val, mx);
      check({tag, "_lock"}, locked, lk);
      check({tag, "_wc"}, window_cnt, exp_wc);
   endtask

   // 16 samples of 0x30 with an extra measurement presented during the DONE cycle.
   task automatic done_window(input string tag, input logic [7:0] dlo, input logic [7:0] dhi,
                              input logic lk);
      send_n(15, 8'h18, 8'h18);
      u_if.phase_valid = 1'b1;
      u_if.phase_diff  = {8'h18, 8'h18};
      tick();
      u_if.phase_diff  = {dhi, dlo};
      check({tag, "_early"}, u_if.stats_valid, 1'b0);
      tick();
      u_if.phase_valid = 1'b0;
      exp_wc++;
      check({tag, "_sv"}, u_if.stats_valid, 1'b1);
      check({tag, "_mean"}, u_if.mean, 9'h030);
      check({tag, "_max"}, u_if.max_val, 9'h030);
      check({tag, "_lock"}, locked, lk);
      check({tag, "_wc"}, window_cnt, exp_wc);
      check({tag, "_rej"}, reject_cnt, 16'd5);
   endtask

   logic [7:0] bad_lo [5] = '{8'h10, 8'h14, 8'h20, 8'h10, 8'h10};
   logic [7:0] bad_hi [5] = '{8'h14, 8'h10, 8'h22, 8'h14, 8'h14};

   initial begin
      rst              = 1'b1;
      enable           = 1'b1;
      u_if.phase_valid = 1'b1;
      u_if.phase_diff  = 16'h2020;
      repeat (3) tick();
      check("rst_mean", u_if.mean, 9'h0);
      check("rst_min", u_if.min_val, 9'h0);
      check("rst_max", u_if.max_val, 9'h0);
      check("rst_sv", u_if.stats_valid, 1'b0);
      check("rst_lock", locked, 1'b0);
      check("rst_wc", window_cnt, 16'h0);
      check("rst_rej", reject_cnt, 16'h0);
      check("rst_to", timeout, 1'b0);
      u_if.phase_valid = 1'b0;
      enable = 1'b0;
      rst    = 1'b0;
      tick();
      enable = 1'b1;
      tick();

      // Basic window
      send_n(16, 8'h20, 8'h20);
      expect_stats("w1", 9'h040, 9'h040, 9'h040, 1'b0);
      tick();
      check("w1_hold_sv", u_if.stats_valid, 1'b0);
      check("w1_hold_mean", u_if.mean, 9'h040);

      // Restart lock counting, then four windows of 0x40/0x41
      enable = 1'b0;
      tick();
      enable = 1'b1;
      tick();
      for (int w = 0; w < 4; w++) begin
         for (int j = 0; j < 8; j++) begin
            send_n(1, 8'h20, 8'h20);
            send_n(1, 8'h20, 8'h21);
         end
         expect_stats($sformatf("alt%0d", w), 9'h040, 9'h040, 9'h041, w == 3);
      end
      for (int j = 0; j < 7; j++) begin
         send_n(1, 8'h20, 8'h20);
         send_n(1, 8'h20, 8'h21);
      end
      send_n(1, 8'h20, 8'h20);
      send_n(1, 8'h24, 8'h24);
      expect_stats("spike", 9'h040, 9'h040, 9'h048, 1'b0);

      // Rejections interleaved with good samples
      for (int i = 0; i < 16; i++) begin
         send_n(1, 8'h30, 8'h30);
         if (i < 5) send_n(1, bad_lo[i], bad_hi[i]);
      end
      expect_stats("rej", 9'h060, 9'h060, 9'h060, 1'b0);
      check("rej_cnt", reject_cnt, 16'd5);
      for (int w = 0; w < 3; w++) begin
         send_n(16, 8'h30, 8'h30);
         expect_stats($sformatf("relock%0d", w), 9'h060, 9'h060, 9'h060, w == 2);
      end

      // Enable drop mid-window
      send_n(7, 8'h50, 8'h50);
      enable = 1'b0;
      tick();
      check("drop_lock", locked, 1'b0);
      check("drop_wc", window_cnt, exp_wc);
      check("drop_mean", u_if.mean, 9'h060);
      enable = 1'b1;
      tick();
      send_n(16, 8'h18, 8'h18);
      expect_stats("redo", 9'h030, 9'h030, 9'h030, 1'b0);

      // Measurements during DONE are ignored
      done_window("doneA", 8'h10, 8'h14, 1'b0);
      done_window("doneB", 8'h7F, 8'h7F, 1'b0);
      send_n(15, 8'h18, 8'h18);
      check("doneC_wait0", u_if.stats_valid, 1'b0);
      tick();
      check("doneC_wait1", u_if.stats_valid, 1'b0);
      tick();
      check("doneC_wait2", u_if.stats_valid, 1'b0);
      send_n(1, 8'h18, 8'h18);
      expect_stats("doneC", 9'h030, 9'h030, 9'h030, 1'b1);

`ifdef PHASE_STATS_TIMEOUT_EN
      send_n(5, 8'h50, 8'h50);
      repeat (99) tick();
      check("to_before", timeout, 1'b0);
      check("to_lock_before", locked, 1'b1);
      tick();
      check("to_set", timeout, 1'b1);
      check("to_lock", locked, 1'b0);
      send_n(1, 8'h18, 8'h18);
      check("to_clear", timeout, 1'b0);
      send_n(15, 8'h18, 8'h18);
      expect_stats("to_win", 9'h030, 9'h030, 9'h030, 1'b0);
`endif

      // Reject counter saturation
      u_if.phase_valid = 1'b1;
      u_if.phase_diff  = {8'h14, 8'h10};
      repeat (65525) @(posedge clk);
      #1;
      check("rej_65530", reject_cnt, 16'd65530);
      repeat (10) @(posedge clk);
      #1;
      check("rej_sat", reject_cnt, 16'hFFFF);
      tick();
      check("rej_sat_hold", reject_cnt, 16'hFFFF);
      u_if.phase_valid = 1'b0;
      check("end_wc", window_cnt, exp_wc);
      check("end_to", timeout, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/phase_stats.md
Name: phase_stats

Overview:
- Sits directly downstream of the echo phase detector.
- Consumes its 16-bit result (two 8-bit tick counts, one per clock edge), combines them into a half-tick-resolution phase value and rejects glitched samples.
- Accumulates fixed-size windows and publishes mean/min/max per window, plus a lock flag that the scope control logic uses to decide when echo timing is stable.

Parameters:
- LOG2_N, 4, log2 of accepted samples per window (N = 16).
- LOCK_TOL, 2, max allowed (max_val - min_val) in half-ticks for a window to count as good.
- LOCK_WINDOWS, 4, consecutive good windows required to assert locked.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run statistics; low returns to IDLE.
- phase_diff  in  16  [7:0] posedge tick count, [15:8] negedge tick count; already synchronous to clk.
- phase_valid  in  1  1-cycle strobe: phase_diff holds a new measurement.
- mean  out  9  window mean in half-ticks, truncated.
- min_val  out  9  window minimum.
- max_val  out  9  window maximum.
- stats_valid  out  1  1-cycle pulse when mean/min/max update.
- locked  out  1  phase stable.
- window_cnt  out  16  completed windows, wraps.
- reject_cnt  out  16  rejected samples, saturates at 0xFFFF.
- timeout  out  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst).
- Reset:
  - All outputs go to 0 and state to IDLE.
  - rst wins over every other input in the same cycle.
- Sample formation:
  - lo = phase_diff[7:0], hi = phase_diff[15:8].
  - combined = lo + hi, 9-bit unsigned, no overflow possible.
- Rejection:
  - A sample is rejected if |lo - hi| > 1, computed unsigned, no wrap.
  - A rejected sample increments reject_cnt (saturating) and is not accumulated.
- Accepted sample: enable && phase_valid && state==ACCUM && not rejected.
- Accumulators:
  - sum is 9+LOG2_N bits; n counts 0..N-1.
  - run_min resets to 0x1FF; run_max resets to 0.
- States:
  - IDLE: outputs hold. When enable=1, go to ACCUM with accumulators cleared on the next edge.
  - ACCUM: each accepted sample updates sum, n, run_min and run_max. The N-th accepted sample moves the state to DONE.
  - DONE, exactly one cycle:
    - phase_valid is ignored: not accumulated, not counted as a reject.
    - On exit edge: mean = sum >> LOG2_N (N-th sample included), min_val/max_val register, stats_valid=1 for one cycle, window_cnt++, lock update, accumulators cleared.
    - Returns to ACCUM, or to IDLE if enable=0.
- Latency: if the N-th accepted sample is presented in cycle k, stats_valid is high in cycle k+2, and outputs hold until the next stats_valid.
- Lock:
  - A window is good if max_val - min_val <= LOCK_TOL. A good window increments the consecutive counter, saturating at LOCK_WINDOWS.
  - locked rises in the same cycle stats_valid shows the LOCK_WINDOWS-th consecutive good window.
  - A bad window clears the counter, and locked falls in the same cycle as its stats_valid.
- enable falling mid-window: state goes to IDLE next edge, partial window is discarded, locked and the lock counter clear. mean/min/max/counters hold.
- phase_valid with enable=0: ignored entirely, including rejection counting.

Optional Feature:
- Macro: PHASE_STATS_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYCLES (default 4096) and a 16-bit idle counter active in ACCUM. The counter clears on any phase_valid, accepted or rejected.
  - When the counter reaches TIMEOUT_CYCLES: timeout is set (sticky), the partial window is discarded, locked and the lock counter clear, and the state stays ACCUM.
  - timeout clears on the next accepted sample.
- Undefined: no counter logic is generated and timeout is constant 0.

Decomposition:
- Package phase_stats_pkg holds:
  - PHASE_W=9, HALF_W=8, CNT_W=16.
  - State enum {IDLE, ACCUM, DONE}.
  - Function for the |lo-hi| reject check.
- Sub-module phase_lock_tracker holds the consecutive-good counter and the locked flag. Inputs: window_done, spread, LOCK_TOL, clear.

Test Plan:
- rst then enable, 16 samples lo=hi=0x20 -> stats_valid in cycle k+2; mean=min_val=max_val=0x040; window_cnt=1; locked=0.
- 4 consecutive windows alternating combined 0x40/0x41 (lo=0x20, hi 0x20/0x21) -> locked=1 with the 4th stats_valid; a 5th window with one sample 0x48 -> locked=0 on that stats_valid.
- Samples lo=0x10, hi=0x14 interleaved with good samples -> reject_cnt increments per bad sample; mean is unaffected; reject_cnt sticks at 0xFFFF after 65536+ rejects.
- Drop enable after 7 samples, re-enable, then 16 samples of 0x030 -> mean=0x030, showing the partial window was discarded; locked was cleared on the drop.
- phase_valid pulsed during the DONE cycle -> not counted: the next window needs a full 16 more accepted samples; reject_cnt unchanged.
- With PHASE_STATS_TIMEOUT_EN, TIMEOUT_CYCLES=100: no phase_valid for 100 cycles -> timeout=1 and locked=0; next good sample -> timeout=0.
